// File: rtl/wb_pkg.sv
// Shared writeback types: unit codes, the per-unit holding slot and the retire classification.
// DATA_W/ADDR_W here are the widths Issue and the Scoreboard agree on.
package wb_pkg;

    localparam int WB_NUM_UNITS = 3;
    localparam int WB_DATA_W    = 32;
    localparam int WB_ADDR_W    = 5;
    localparam int WB_UNIT_W    = 2;

    typedef enum logic [WB_UNIT_W-1:0] {
        UNIT_ALU   = 2'd0,
        UNIT_SHIFT = 2'd1,
        UNIT_MEM   = 2'd2
    } unit_e;

    typedef struct packed {
        logic                 valid;
        logic [WB_DATA_W-1:0] data;
        logic [WB_ADDR_W-1:0] regdest;
        logic                 writereg;
        logic                 writeov;
        logic                 ov;
    } wb_slot_t;

    typedef enum logic [1:0] {
        RET_NONE  = 2'd0,
        RET_TRAP  = 2'd1,
        RET_WRITE = 2'd2
    } retire_e;

    // Trap wins over the write; r0 writes and stores retire silently.
    function automatic retire_e retire_kind(input wb_slot_t s);
        if (!s.valid)
            return RET_NONE;
        else if (s.writeov && s.ov)
            return RET_TRAP;
        else if (s.writereg && (s.regdest != '0))
            return RET_WRITE;
        else
            return RET_NONE;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Execute-side result handshake plus the regfile/scoreboard writeback outputs.
// master: execute units and writeback consumers; slave: the arbiter.
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int NUM_UNITS = WB_NUM_UNITS,
    parameter int DATA_W    = WB_DATA_W,
    parameter int ADDR_W    = WB_ADDR_W,
    parameter int UNIT_W    = WB_UNIT_W
);
    logic [NUM_UNITS-1:0]        fu_wb_valid;
    logic [NUM_UNITS-1:0]        fu_wb_ready;
    logic [NUM_UNITS*DATA_W-1:0] fu_wb_data;
    logic [NUM_UNITS*ADDR_W-1:0] fu_wb_regdest;
    logic [NUM_UNITS-1:0]        fu_wb_writereg;
    logic [NUM_UNITS-1:0]        fu_wb_writeov;
    logic [NUM_UNITS-1:0]        fu_wb_ov;

    logic                        wb_reg_enablewrite;
    logic [ADDR_W-1:0]           wb_reg_writeaddr;
    logic [DATA_W-1:0]           wb_reg_writedata;
    logic                        wb_sb_clear;
    logic [ADDR_W-1:0]           wb_sb_clearaddr;
    logic [UNIT_W-1:0]           wb_sb_clearunit;
    logic                        wb_exception;
    logic [UNIT_W-1:0]           wb_exception_unit;
    logic                        wb_busy;

    modport master (
        output fu_wb_valid, fu_wb_data, fu_wb_regdest,
               fu_wb_writereg, fu_wb_writeov, fu_wb_ov,
        input  fu_wb_ready,
        input  wb_reg_enablewrite, wb_reg_writeaddr, wb_reg_writedata,
               wb_sb_clear, wb_sb_clearaddr, wb_sb_clearunit,
               wb_exception, wb_exception_unit, wb_busy
    );

    modport slave (
        input  fu_wb_valid, fu_wb_data, fu_wb_regdest,
               fu_wb_writereg, fu_wb_writeov, fu_wb_ov,
        output fu_wb_ready,
        output wb_reg_enablewrite, wb_reg_writeaddr, wb_reg_writedata,
               wb_sb_clear, wb_sb_clearaddr, wb_sb_clearunit,
               wb_exception, wb_exception_unit, wb_busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping modulo N.
// Produces a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Scan from the farthest offset down so the nearest requester is the last to win.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            automatic int idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant       = '0;
                grant[idx]  = 1'b1;
                grant_idx   = IDX_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per functional unit, round-robin retire of one slot
// per cycle into a registered regfile write / scoreboard clear / overflow trap.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_UNITS = WB_NUM_UNITS,
    parameter int DATA_W    = WB_DATA_W,
    parameter int ADDR_W    = WB_ADDR_W,
    parameter int UNIT_W    = WB_UNIT_W
) (
    input logic         clock,
    input logic         reset,
    wb_arbiter_if.slave bus
);

    wb_slot_t             slot_q [NUM_UNITS];
    wb_slot_t             fu_slot [NUM_UNITS];
    wb_slot_t             gnt_slot;
    logic [NUM_UNITS-1:0] slot_valid;
    logic [NUM_UNITS-1:0] grant;
    logic [NUM_UNITS-1:0] ready;
    logic [NUM_UNITS-1:0] capture;
    logic [UNIT_W-1:0]    rr_ptr;
    logic [UNIT_W-1:0]    grant_idx;
    logic                 grant_valid;
    retire_e              ret_kind;

    logic                 reg_enablewrite;
    logic [ADDR_W-1:0]    reg_writeaddr;
    logic [DATA_W-1:0]    reg_writedata;
    logic                 sb_clear;
    logic [ADDR_W-1:0]    sb_clearaddr;
    logic [UNIT_W-1:0]    sb_clearunit;
    logic                 exception;
    logic [UNIT_W-1:0]    exception_unit;

    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            slot_valid[i]       = slot_q[i].valid;
            fu_slot[i].valid    = 1'b1;
            fu_slot[i].data     = bus.fu_wb_data[i*DATA_W +: DATA_W];
            fu_slot[i].regdest  = bus.fu_wb_regdest[i*ADDR_W +: ADDR_W];
            fu_slot[i].writereg = bus.fu_wb_writereg[i];
            fu_slot[i].writeov  = bus.fu_wb_writeov[i];
            fu_slot[i].ov       = bus.fu_wb_ov[i];
        end
    end

    rr_arbiter #(
        .N     (NUM_UNITS),
        .IDX_W (UNIT_W)
    ) u_rr_arbiter (
        .req         (slot_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // A slot being retired this cycle may be refilled in the same cycle.
    assign ready           = ~slot_valid | grant;
    assign capture         = bus.fu_wb_valid & ready;
    assign bus.fu_wb_ready = ready;
    assign bus.wb_busy     = |slot_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_UNITS; i++)
                slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (capture[i])
                    slot_q[i] <= fu_slot[i];
                else if (grant[i])
                    slot_q[i].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= '0;
        else if (grant_valid)
            rr_ptr <= (grant_idx == UNIT_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        gnt_slot = '0;
        for (int i = 0; i < NUM_UNITS; i++)
            if (grant[i])
                gnt_slot = slot_q[i];
    end

    assign ret_kind = grant_valid ? retire_kind(gnt_slot) : RET_NONE;

    // Strobes pulse for one cycle; address/data/unit fields keep their last value.
    always_ff @(posedge clock) begin
        if (reset) begin
            reg_enablewrite <= 1'b0;
            reg_writeaddr   <= '0;
            reg_writedata   <= '0;
            sb_clear        <= 1'b0;
            sb_clearaddr    <= '0;
            sb_clearunit    <= '0;
            exception       <= 1'b0;
            exception_unit  <= '0;
        end else begin
            reg_enablewrite <= 1'b0;
            sb_clear        <= 1'b0;
            exception       <= 1'b0;
            case (ret_kind)
                RET_TRAP: begin
                    exception      <= 1'b1;
                    exception_unit <= grant_idx;
                    sb_clear       <= 1'b1;
                    sb_clearaddr   <= gnt_slot.regdest;
                    sb_clearunit   <= grant_idx;
                end
                RET_WRITE: begin
                    reg_enablewrite <= 1'b1;
                    reg_writeaddr   <= gnt_slot.regdest;
                    reg_writedata   <= gnt_slot.data;
                    sb_clear        <= 1'b1;
                    sb_clearaddr    <= gnt_slot.regdest;
                    sb_clearunit    <= grant_idx;
                end
                default: ;
            endcase
        end
    end

    assign bus.wb_reg_enablewrite = reg_enablewrite;
    assign bus.wb_reg_writeaddr   = reg_writeaddr;
    assign bus.wb_reg_writedata   = reg_writedata;
    assign bus.wb_sb_clear        = sb_clear;
    assign bus.wb_sb_clearaddr    = sb_clearaddr;
    assign bus.wb_sb_clearunit    = sb_clearunit;
    assign bus.wb_exception       = exception;
    assign bus.wb_exception_unit  = exception_unit;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: handshake latency, round-robin order, trap/r0/store
// retire kinds, streaming backpressure with a per-unit scoreboard, and mid-run reset.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic set_unit(input int u, input logic [31:0] d, input logic [4:0] rd,
                            input logic wr, input logic wov, input logic ovf);
        bus.fu_wb_valid[u]          = 1'b1;
        bus.fu_wb_data[u*32 +: 32]  = d;
        bus.fu_wb_regdest[u*5 +: 5] = rd;
        bus.fu_wb_writereg[u]       = wr;
        bus.fu_wb_writeov[u]        = wov;
        bus.fu_wb_ov[u]             = ovf;
    endtask

    task automatic idle();
        bus.fu_wb_valid = '0;
    endtask

    task automatic expect_write(input string tag, input logic [4:0] addr,
                                input logic [31:0] data, input logic [1:0] unit);
        check({tag, "_we"},     bus.wb_reg_enablewrite, 1'b1);
        check({tag, "_waddr"},  bus.wb_reg_writeaddr, addr);
        check({tag, "_wdata"},  bus.wb_reg_writedata, data);
        check({tag, "_clr"},    bus.wb_sb_clear, 1'b1);
        check({tag, "_caddr"},  bus.wb_sb_clearaddr, addr);
        check({tag, "_cunit"},  bus.wb_sb_clearunit, unit);
        check({tag, "_exc"},    bus.wb_exception, 1'b0);
    endtask

    task automatic expect_quiet(input string tag);
        check({tag, "_we"},  bus.wb_reg_enablewrite, 1'b0);
        check({tag, "_clr"}, bus.wb_sb_clear, 1'b0);
        check({tag, "_exc"}, bus.wb_exception, 1'b0);
    endtask

    function automatic logic [31:0] sdata(input int u, input int s);
        return 32'hA500_0000 | 32'(u << 8) | 32'(s);
    endfunction

    function automatic logic [4:0] saddr(input int u, input int s);
        return 5'(8 + u * 4 + s);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent [3];
        int got [3];
        int retired;
        int u;
        logic saw_r2_low;
        logic [2:0] r;
        logic [2:0] hs;

        reset = 1'b1;
        bus.fu_wb_valid    = '0;
        bus.fu_wb_data     = '0;
        bus.fu_wb_regdest  = '0;
        bus.fu_wb_writereg = '0;
        bus.fu_wb_writeov  = '0;
        bus.fu_wb_ov       = '0;
        repeat (2) @(posedge clock);
        step();
        reset = 1'b0;

        // Reset state
        check("rst_ready", bus.fu_wb_ready, 3'b111);
        check("rst_busy", bus.wb_busy, 1'b0);
        expect_quiet("rst");
        check("rst_waddr", bus.wb_reg_writeaddr, 5'd0);
        check("rst_wdata", bus.wb_reg_writedata, 32'd0);
        check("rst_cunit", bus.wb_sb_clearunit, 2'd0);
        check("rst_eunit", bus.wb_exception_unit, 2'd0);

        // Contention from rr_ptr=0: order 0,1,2
        for (int i = 0; i < 3; i++) set_unit(i, 32'h0A00 + 32'(i), 5'(i + 1), 1'b1, 1'b0, 1'b0);
        step();
        idle();
        check("ctA_ready0", bus.fu_wb_ready, 3'b001);
        check("ctA_busy", bus.wb_busy, 1'b1);
        expect_quiet("ctA_lat");
        step();
        expect_write("ctA_1", 5'd1, 32'h0A00, 2'd0);
        check("ctA_ready1", bus.fu_wb_ready, 3'b011);
        step();
        expect_write("ctA_2", 5'd2, 32'h0A01, 2'd1);
        step();
        expect_write("ctA_3", 5'd3, 32'h0A02, 2'd2);
        check("ctA_busy_end", bus.wb_busy, 1'b0);
        step();
        expect_quiet("ctA_done");

        // Single ALU result
        set_unit(0, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        check("alu_busy", bus.wb_busy, 1'b1);
        expect_quiet("alu_lat");
        step();
        expect_write("alu", 5'd5, 32'h1234, 2'd0);
        step();
        expect_quiet("alu_once");

        // Contention from rr_ptr=1: order 1,2,0
        for (int i = 0; i < 3; i++) set_unit(i, 32'h0B00 + 32'(i), 5'(i + 1), 1'b1, 1'b0, 1'b0);
        step();
        idle();
        check("ctB_ready0", bus.fu_wb_ready, 3'b010);
        step();
        expect_write("ctB_1", 5'd2, 32'h0B01, 2'd1);
        step();
        expect_write("ctB_2", 5'd3, 32'h0B02, 2'd2);
        step();
        expect_write("ctB_3", 5'd1, 32'h0B00, 2'd0);
        step();
        expect_quiet("ctB_done");

        // Overflow trap on unit 0
        set_unit(0, 32'h0000_DEAD, 5'd7, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        step();
        check("ov0_exc", bus.wb_exception, 1'b1);
        check("ov0_eunit", bus.wb_exception_unit, 2'd0);
        check("ov0_we", bus.wb_reg_enablewrite, 1'b0);
        check("ov0_clr", bus.wb_sb_clear, 1'b1);
        check("ov0_caddr", bus.wb_sb_clearaddr, 5'd7);
        check("ov0_cunit", bus.wb_sb_clearunit, 2'd0);
        check("ov0_waddr_hold", bus.wb_reg_writeaddr, 5'd1);
        check("ov0_wdata_hold", bus.wb_reg_writedata, 32'h0B00);
        step();
        expect_quiet("ov0_pulse");

        // Overflow trap on unit 1
        set_unit(1, 32'h0000_BEEF, 5'd9, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        step();
        check("ov1_exc", bus.wb_exception, 1'b1);
        check("ov1_eunit", bus.wb_exception_unit, 2'd1);
        check("ov1_cunit", bus.wb_sb_clearunit, 2'd1);
        check("ov1_caddr", bus.wb_sb_clearaddr, 5'd9);
        check("ov1_we", bus.wb_reg_enablewrite, 1'b0);
        step();

        // ov without writeov, and writeov without ov: normal writes
        set_unit(0, 32'h0000_0077, 5'd7, 1'b1, 1'b0, 1'b1);
        step();
        idle();
        step();
        expect_write("noov_a", 5'd7, 32'h77, 2'd0);
        set_unit(2, 32'h0000_000C, 5'd12, 1'b1, 1'b1, 1'b0);
        step();
        idle();
        step();
        expect_write("noov_b", 5'd12, 32'hC, 2'd2);
        step();

        // Write to r0: no write, no clear
        set_unit(2, 32'h0000_5555, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        step();
        expect_quiet("r0");
        check("r0_busy", bus.wb_busy, 1'b0);
        check("r0_caddr_hold", bus.wb_sb_clearaddr, 5'd12);

        // Store (no writereg)
        set_unit(1, 32'h0000_6666, 5'd4, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        check("st_busy", bus.wb_busy, 1'b1);
        check("st_ready", bus.fu_wb_ready, 3'b111);
        step();
        expect_quiet("st");
        check("st_busy_end", bus.wb_busy, 1'b0);
        check("st_ready_end", bus.fu_wb_ready, 3'b111);

        // Streaming with backpressure: every result retires once, in per-unit order
        for (int i = 0; i < 3; i++) begin
            sent[i] = 0;
            got[i]  = 0;
        end
        retired    = 0;
        saw_r2_low = 1'b0;
        for (int cyc = 0; cyc < 60 && retired < 12; cyc++) begin
            if (bus.wb_reg_enablewrite) begin
                u = int'(bus.wb_sb_clearunit);
                check("stream_unit_range", (u < 3), 1'b1);
                if (u < 3) begin
                    check("stream_data", bus.wb_reg_writedata, sdata(u, got[u]));
                    check("stream_addr", bus.wb_reg_writeaddr, saddr(u, got[u]));
                    check("stream_clr", bus.wb_sb_clear, 1'b1);
                    got[u]++;
                end
                retired++;
            end
            for (int i = 0; i < 3; i++) begin
                if (sent[i] < 4)
                    set_unit(i, sdata(i, sent[i]), saddr(i, sent[i]), 1'b1, 1'b0, 1'b0);
                else
                    bus.fu_wb_valid[i] = 1'b0;
            end
            r  = bus.fu_wb_ready;
            hs = bus.fu_wb_valid & r;
            if (bus.fu_wb_valid[2] && !r[2]) saw_r2_low = 1'b1;
            @(posedge clock);
            @(negedge clock);
            for (int i = 0; i < 3; i++) if (hs[i]) sent[i]++;
        end
        idle();
        check("stream_retired", retired, 12);
        for (int i = 0; i < 3; i++) check("stream_per_unit", got[i], 4);
        check("stream_r2_backpressure", saw_r2_low, 1'b1);
        step();
        expect_quiet("stream_done");

        // Mid-operation reset: park rr_ptr at 1, fill all slots, reset for one cycle
        set_unit(0, 32'h0000_0001, 5'd6, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        step();
        expect_write("pre_rst", 5'd6, 32'h1, 2'd0);
        for (int i = 0; i < 3; i++) set_unit(i, 32'h0C00 + 32'(i), 5'(20 + i), 1'b1, 1'b0, 1'b0);
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_quiet("mrst");
        check("mrst_ready", bus.fu_wb_ready, 3'b111);
        check("mrst_busy", bus.wb_busy, 1'b0);
        check("mrst_waddr", bus.wb_reg_writeaddr, 5'd0);
        step();
        expect_quiet("mrst_next");
        for (int i = 0; i < 3; i++) set_unit(i, 32'h0D00 + 32'(i), 5'(i + 1), 1'b1, 1'b0, 1'b0);
        step();
        idle();
        step();
        expect_write("mrst_o1", 5'd1, 32'h0D00, 2'd0);
        step();
        expect_write("mrst_o2", 5'd2, 32'h0D01, 2'd1);
        step();
        expect_write("mrst_o3", 5'd3, 32'h0D02, 2'd2);
        step();
        expect_quiet("mrst_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
